cache_fill_controller: RTL
==========================

Name: cache_fill_controller

Overview:
- Direct-mapped cache controller sitting directly upstream of the miss block-fetch stage (request_block).
- Accepts byte-read requests, looks up tag/valid state, and returns the byte on a hit.
- On a miss it restarts and drives the fetch stage, captures the returned line on block_ready, fills the line, then responds.
- Also keeps hit/miss statistics for the multicore simulator.

Parameters:
- way, 1: associativity; only 1 is supported.
- block_size_byte, 16: line size in bytes; legal values 4, 8, 16.
- cache_size_byte, 32*1024: total data capacity in bytes.
- fetch_timeout, 64: maximum FETCH_WAIT cycles before the fetch is abandoned.
- Derived: block_offset_index = log2(block_size_byte); set = cache_size_byte/(block_size_byte*way); set_index = log2(set).
- Derived: tag width TW = 16 - set_index - block_offset_index.

Ports:
- clk3  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_addr  in  16  byte address {tag, index, offset}.
- req_ready  out  1  controller idle; a request is accepted when req_valid & req_ready.
- resp_valid  out  1  one-cycle pulse; resp_data valid.
- resp_data  out  8  requested byte.
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = filled miss.
- fetch_error  out  1  one-cycle pulse on fetch timeout.
- found_in_cache  out  1  to fetch stage; 0 = fetch enabled.
- fetch_reset  out  1  to fetch stage reset; restarts its byte counters.
- tag  out  TW  line tag to fetch stage.
- index  out  set_index  line index to fetch stage.
- block_offset  out  block_offset_index  latched offset.
- block  in  block_size_byte*8  fetched line; byte k = block[8k+7:8k].
- block_ready  in  1  one-cycle pulse; block is valid in that cycle.
- hit_count  out  16  saturating hit counter.
- miss_count  out  16  saturating miss counter.

Behaviour:
- Storage:
  - valid bit vector [set], cleared by reset.
  - tag array [set] x TW.
  - data array [set] x line; tag and data arrays are not reset.
- Reset values:
  - fetch_reset=1 and found_in_cache=1.
  - All other outputs 0; state=IDLE.
  - fetch_reset deasserts on the first clk3 edge after reset release.
- IDLE: req_ready=1. On an accepted request, latch tag/index/offset into the tag/index/block_offset outputs and go to LOOKUP. req_ready=0 in every other state; req_valid is ignored there.
- LOOKUP (1 cycle):
  - Hit = valid[index] && tag_array[index]==tag.
  - Hit: latch byte[offset] of the stored line, increment hit_count, go to RESPOND with resp_hit=1.
  - Miss: increment miss_count, go to FETCH_RST.
- FETCH_RST (1 cycle): fetch_reset=1, found_in_cache=1. Go to FETCH_WAIT.
- FETCH_WAIT:
  - found_in_cache=0; a timeout counter increments each cycle.
  - On block_ready: write block into data[index], tag into tag_array[index], set valid[index]; latch byte[offset] from the block input; go to RESPOND with resp_hit=0.
  - When the counter reaches fetch_timeout without block_ready: pulse fetch_error, leave the line untouched, go to IDLE with no resp_valid.
- RESPOND (1 cycle): resp_valid=1 with resp_data and resp_hit. found_in_cache returns to 1. Go to IDLE.
- Latency:
  - Accept edge E.
  - Hit: resp_valid is high in the cycle after edge E+2.
  - Miss: resp_valid is high in the cycle after the edge that sampled block_ready, plus 1.
- Boundaries:
  - block_ready outside FETCH_WAIT is ignored.
  - block_ready in the same cycle the timeout is reached: fill wins, no error.
  - Eviction overwrites the resident line unconditionally; no write-back.
  - Counters stick at 16'hFFFF.
  - Asynchronous reset mid-fetch: valid bits cleared, FSM returns to IDLE, fetch_reset=1, counters cleared.
- Widths: byte select is block >> (8*offset), truncated to 8 bits.

Test Plan (defaults: index 11 bits, offset 4 bits, tag 1 bit):
- Cold miss: req 16'h1234, block_ready after 20 cycles with block=128'h0F0E0D0C0B0A09080706050403020100. Required: fetch_reset pulse and found_in_cache=0 with tag=0, index=11'h123; resp_data=8'h04, resp_hit=0, miss_count=1.
- Re-hit: req 16'h123A. Required: resp_data=8'h0A, resp_hit=1 exactly 3 edges after accept, found_in_cache stays 1, hit_count=1.
- Conflict: req 16'h9234 (tag 1, same index) -> miss and refetch. Then req 16'h1234 -> miss again. miss_count=3.
- Timeout: miss with block_ready never asserted. Required: fetch_error pulse at cycle 64 of FETCH_WAIT, no resp_valid, req_ready=1 afterwards, line still invalid (a later request misses).
- Reset mid-FETCH_WAIT. Required: outputs at reset values immediately (asynchronous), fetch_reset=1, counters 0. After release, the previously filled address misses.
- Busy ignore: hold req_valid during FETCH_WAIT with a different address. Required: exactly one response per accepted request, and the latched tag/index do not change.

Source files
------------

// File: rtl/cache_fill_controller.sv
// -----------------------------------------------------------------------------
// cache_fill_controller
//
// Direct-mapped, read-only byte cache in front of a line-fetch stage.
// A request is looked up against the tag/valid arrays. A hit returns the byte
// from the resident line. A miss restarts the fetch stage, waits for the fetched
// line, fills it, and then returns the byte. A fetch that does not complete
// within fetch_timeout cycles is abandoned and reported on fetch_error.
// Saturating hit/miss counters are kept for statistics.
//
// Handshake: a request is accepted on a clk3 edge where req_valid && req_ready.
// req_ready is high only while idle. resp_valid is a one-cycle pulse, and
// resp_data/resp_hit are valid with it. block_ready is a one-cycle pulse, and
// block is valid in that cycle. block_ready is ignored unless a fetch is pending.
//
// Ports:
//   clk3, reset                 clock, asynchronous active-high reset
//   req_valid/req_addr/req_ready  byte-read request {tag, index, offset}
//   resp_valid/resp_data/resp_hit response (hit=1, filled miss=0)
//   fetch_error                 one-cycle pulse when a fetch is abandoned
//   found_in_cache, fetch_reset control to the fetch stage (0 = fetch enabled)
//   tag/index/block_offset      latched request fields driven to the fetch stage
//   block/block_ready           fetched line returned by the fetch stage
//   hit_count/miss_count        saturating statistics
//   dbg_state                   current FSM state, for observation only
// -----------------------------------------------------------------------------
module cache_fill_controller #(
  parameter int way             = 1,
  parameter int block_size_byte = 16,
  parameter int cache_size_byte = 32*1024,
  parameter int fetch_timeout   = 64,
  localparam int block_offset_index = $clog2(block_size_byte),
  localparam int set                = cache_size_byte/(block_size_byte*way),
  localparam int set_index          = $clog2(set),
  localparam int TW                 = 16 - set_index - block_offset_index,
  localparam int LW                 = block_size_byte*8
) (
  input  logic                          clk3,
  input  logic                          reset,
  input  logic                          req_valid,
  input  logic [15:0]                   req_addr,
  output logic                          req_ready,
  output logic                          resp_valid,
  output logic [7:0]                    resp_data,
  output logic                          resp_hit,
  output logic                          fetch_error,
  output logic                          found_in_cache,
  output logic                          fetch_reset,
  output logic [TW-1:0]                 tag,
  output logic [set_index-1:0]          index,
  output logic [block_offset_index-1:0] block_offset,
  input  logic [LW-1:0]                 block,
  input  logic                          block_ready,
  output logic [15:0]                   hit_count,
  output logic [15:0]                   miss_count,
  output logic [2:0]                    dbg_state
);

  localparam int TO_W = $clog2(fetch_timeout + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOOKUP     = 3'd1,
    S_FETCH_RST  = 3'd2,
    S_FETCH_WAIT = 3'd3,
    S_RESPOND    = 3'd4
  } state_t;

  state_t                          r_state;
  logic [set-1:0]                  r_valid;
  logic [TW-1:0]                   r_tag_mem  [set];
  logic [LW-1:0]                   r_data_mem [set];
  logic [TO_W-1:0]                 r_to_cnt;
  logic                            r_req_ready;
  logic                            r_resp_valid;
  logic [7:0]                      r_resp_data;
  logic                            r_resp_hit;
  logic                            r_fetch_error;
  logic                            r_found;
  logic                            r_fetch_reset;
  logic [TW-1:0]                   r_tag;
  logic [set_index-1:0]            r_index;
  logic [block_offset_index-1:0]   r_offset;
  logic [15:0]                     r_hits;
  logic [15:0]                     r_misses;

  logic                            w_hit;
  logic                            w_fill;
  logic [LW-1:0]                   w_src_line;
  logic [LW-1:0]                   w_shifted;
  logic [7:0]                      w_byte;

  assign w_hit  = r_valid[r_index] && (r_tag_mem[r_index] == r_tag);
  assign w_fill = (r_state == S_FETCH_WAIT) && block_ready;

  // During a fill the byte comes straight from the incoming line; otherwise
  // it comes from the resident line.
  assign w_src_line = (r_state == S_FETCH_WAIT) ? block : r_data_mem[r_index];
  assign w_shifted  = w_src_line >> {r_offset, 3'b000};
  assign w_byte     = w_shifted[7:0];

  // Tag and data arrays have no reset; only the valid bits are cleared.
  always_ff @(posedge clk3) begin
    if (w_fill) begin
      r_tag_mem[r_index]  <= r_tag;
      r_data_mem[r_index] <= block;
    end
  end

  always_ff @(posedge clk3 or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_valid       <= '0;
      r_to_cnt      <= '0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= 8'h00;
      r_resp_hit    <= 1'b0;
      r_fetch_error <= 1'b0;
      r_found       <= 1'b1;
      r_fetch_reset <= 1'b1;
      r_tag         <= '0;
      r_index       <= '0;
      r_offset      <= '0;
      r_hits        <= 16'h0000;
      r_misses      <= 16'h0000;
    end else begin
      r_resp_valid  <= 1'b0;
      r_fetch_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_fetch_reset <= 1'b0;
          r_found       <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_tag       <= req_addr[15 -: TW];
            r_index     <= req_addr[block_offset_index +: set_index];
            r_offset    <= req_addr[block_offset_index-1:0];
            r_state     <= S_LOOKUP;
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            r_resp_data <= w_byte;
            r_resp_hit  <= 1'b1;
            if (r_hits != 16'hFFFF) r_hits <= r_hits + 16'h0001;
            r_state     <= S_RESPOND;
          end else begin
            if (r_misses != 16'hFFFF) r_misses <= r_misses + 16'h0001;
            r_fetch_reset <= 1'b1;
            r_state       <= S_FETCH_RST;
          end
        end
        S_FETCH_RST: begin
          r_fetch_reset <= 1'b0;
          r_found       <= 1'b0;
          r_to_cnt      <= '0;
          r_state       <= S_FETCH_WAIT;
        end
        S_FETCH_WAIT: begin
          // A fill arriving on the final allowed cycle takes priority over the timeout.
          if (block_ready) begin
            r_valid[r_index] <= 1'b1;
            r_resp_data      <= w_byte;
            r_resp_hit       <= 1'b0;
            r_found          <= 1'b1;
            r_state          <= S_RESPOND;
          end else if (r_to_cnt == TO_W'(fetch_timeout - 1)) begin
            r_fetch_error <= 1'b1;
            r_found       <= 1'b1;
            r_req_ready   <= 1'b1;
            r_state       <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_RESPOND: begin
          r_resp_valid <= 1'b1;
          r_req_ready  <= 1'b1;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_hit       = r_resp_hit;
  assign fetch_error    = r_fetch_error;
  assign found_in_cache = r_found;
  assign fetch_reset    = r_fetch_reset;
  assign tag            = r_tag;
  assign index          = r_index;
  assign block_offset   = r_offset;
  assign hit_count      = r_hits;
  assign miss_count     = r_misses;
  assign dbg_state      = r_state;

endmodule
